// File: rtl/cpu_control_fsm.sv
// Instruction-register holder and MOV/ALU sequencer for the 16-bit datapath.
// Moore machine: all strobes are decoded from the current state and the IR.
module cpu_control_fsm #(
   parameter int unsigned DATA_W     = 16,
   parameter int unsigned REG_ADDR_W = 3
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  s,
   input  logic                  load,
   input  logic [15:0]           in,
   output logic                  w,
   output logic [REG_ADDR_W-1:0] readnum,
   output logic [REG_ADDR_W-1:0] writenum,
   output logic                  write,
   output logic [1:0]            vsel,
   output logic                  loada,
   output logic                  loadb,
   output logic                  loadc,
   output logic                  loads,
   output logic                  asel,
   output logic                  bsel,
   output logic [1:0]            shift,
   output logic [1:0]            ALUop,
   output logic [DATA_W-1:0]     sximm8,
   output logic [DATA_W-1:0]     sximm5
);

   typedef enum logic [2:0] {
      S_WAIT, S_DECODE, S_WR_IMM, S_GET_A, S_GET_B, S_EXEC, S_WR_REG
   } state_t;

   state_t      state_q, state_d;
   logic [15:0] ir_q, ir_d;

   logic [2:0] opcode, rn, rd, rm;
   logic [1:0] op, sh;
   logic       is_mov_imm, is_mov_reg, is_alu, is_cmp, is_mvn;

   assign opcode = ir_q[15:13];
   assign op     = ir_q[12:11];
   assign rn     = ir_q[10:8];
   assign rd     = ir_q[7:5];
   assign sh     = ir_q[4:3];
   assign rm     = ir_q[2:0];

   assign is_mov_imm = (opcode == 3'b110) && (op == 2'b10);
   assign is_mov_reg = (opcode == 3'b110) && (op == 2'b00);
   assign is_alu     = (opcode == 3'b101);
   assign is_cmp     = is_alu && (op == 2'b01);
   assign is_mvn     = is_alu && (op == 2'b11);

   assign sximm8 = {{(DATA_W-8){ir_q[7]}}, ir_q[7:0]};
   assign sximm5 = {{(DATA_W-5){ir_q[4]}}, ir_q[4:0]};

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_WAIT;
         ir_q    <= '0;
      end else begin
         state_q <= state_d;
         ir_q    <= ir_d;
      end
   end

   always_comb begin
      state_d = state_q;
      ir_d    = ir_q;
      unique case (state_q)
         S_WAIT: begin
            if (load) ir_d = in;
            if (s) state_d = S_DECODE;
         end
         S_DECODE: begin
            // Unknown encodings fall straight back to WAIT with no strobes.
            if (is_mov_imm)                state_d = S_WR_IMM;
            else if (is_mov_reg || is_mvn) state_d = S_GET_B;
            else if (is_alu)               state_d = S_GET_A;
            else                           state_d = S_WAIT;
         end
         S_WR_IMM: state_d = S_WAIT;
         S_GET_A:  state_d = S_GET_B;
         S_GET_B:  state_d = S_EXEC;
         S_EXEC:   state_d = is_cmp ? S_WAIT : S_WR_REG;
         S_WR_REG: state_d = S_WAIT;
         default:  state_d = S_WAIT;
      endcase
   end

   always_comb begin
      w        = 1'b0;
      readnum  = '0;
      writenum = '0;
      write    = 1'b0;
      vsel     = 2'b00;
      loada    = 1'b0;
      loadb    = 1'b0;
      loadc    = 1'b0;
      loads    = 1'b0;
      asel     = 1'b0;
      bsel     = 1'b0;
      shift    = 2'b00;
      ALUop    = 2'b00;
      unique case (state_q)
         S_WAIT: w = 1'b1;
         S_WR_IMM: begin
            vsel     = 2'b01;
            write    = 1'b1;
            writenum = REG_ADDR_W'(rn);
         end
         S_GET_A: begin
            readnum = REG_ADDR_W'(rn);
            loada   = 1'b1;
         end
         S_GET_B: begin
            readnum = REG_ADDR_W'(rm);
            loadb   = 1'b1;
            shift   = sh;
         end
         S_EXEC: begin
            shift = sh;
            ALUop = is_mov_reg ? 2'b00 : op;
            asel  = is_mov_reg;
            loads = is_cmp;
            loadc = !is_cmp;
         end
         S_WR_REG: begin
            write    = 1'b1;
            writenum = REG_ADDR_W'(rd);
         end
         default: ;
      endcase
   end

endmodule
